// File: rtl/cmd_tx_sequencer.sv
// cmd_tx_sequencer: arbitrates two requesters and streams a BRAM packet template as a byte stream
module cmd_tx_sequencer #(
  parameter logic [10:0] BASE0 = 11'd0,
  parameter logic [10:0] BASE1 = 11'd1024,
  parameter int MAX_LEN = 1024,
  parameter int IFG = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  output logic [1:0]  ack,
  output logic        busy,
  output logic [10:0] mem_adb,
  output logic        mem_ceb,
  output logic        mem_oce,
  input  logic [8:0]  mem_dout,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        tx_last,
  input  logic        tx_ready,
  output logic        len_err
);
  typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;
  state_t state, state_nx;
  logic ptr, inflight, stop, head, gnt, gsel, push, pop, issue, forced, flag_in, last_xfer;
  logic [10:0] rd_addr, pcnt;
  logic [7:0] gap_cnt;
  logic [1:0] count;
  logic [2:0] room;
  logic [8:0] fifo [2];
  assign gnt = state == IDLE && req != 2'b00;
  assign gsel = (req == 2'b11) ? ptr : req[1];
  assign push = state == STREAM && inflight && !stop;
  assign forced = push && pcnt == 11'(MAX_LEN - 1);
  assign flag_in = mem_dout[8] || forced;
  assign len_err = forced && !mem_dout[8];
  assign tx_valid = count != 2'd0;
  assign pop = tx_valid && tx_ready;
  assign tx_data = fifo[head][7:0];
  assign tx_last = tx_valid && fifo[head][8];
  assign last_xfer = pop && fifo[head][8];
  // occupancy after this cycle's pop, counting the read still in flight
  assign room = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
  assign issue = state == STREAM && !stop && room < 3'd2;
  assign mem_ceb = issue;
  assign mem_adb = issue ? rd_addr : 11'd0;
  assign mem_oce = 1'b1;
  assign busy = state != IDLE;
  always_comb begin
    state_nx = state;
    state_nx = gnt ? STREAM :
               (state == STREAM && last_xfer) ? ((IFG == 0) ? IDLE : GAP) :
               (state == GAP && gap_cnt == 8'd0) ? IDLE : state;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack <= 2'b00;
      ptr <= 1'b0;
      inflight <= 1'b0;
      stop <= 1'b0;
      rd_addr <= 11'd0;
      pcnt <= 11'd0;
      gap_cnt <= 8'd0;
      count <= 2'd0;
      head <= 1'b0;
      fifo[0] <= 9'd0;
      fifo[1] <= 9'd0;
    end else begin
      ack <= gnt ? (gsel ? 2'b10 : 2'b01) : 2'b00;
      inflight <= issue;
      if (gnt) begin
        ptr <= ~gsel;
        rd_addr <= gsel ? BASE1 : BASE0;
        pcnt <= 11'd0;
        stop <= 1'b0;
      end else if (issue) rd_addr <= rd_addr + 11'd1;
      if (push) begin
        fifo[head ^ count[0]] <= {flag_in, mem_dout[7:0]};
        pcnt <= pcnt + 11'd1;
        if (flag_in) stop <= 1'b1;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
      if (pop) head <= ~head;
      if (last_xfer) gap_cnt <= 8'(IFG - 1);
      else if (state == GAP) gap_cnt <= gap_cnt - 8'd1;
    end
  end
endmodule

// File: tb/tb_cmd_tx_sequencer.sv
// tb_cmd_tx_sequencer: directed checks of arbitration, streaming, backpressure, length guard and reset abort
`timescale 1ns/1ps
module tb_cmd_tx_sequencer;
  logic clk = 1'b0, reset = 1'b1, tx_ready = 1'b1;
  logic [1:0] req = 2'b00, ack;
  logic busy, mem_ceb, mem_oce, tx_valid, tx_last, len_err;
  logic [10:0] mem_adb;
  logic [8:0] mem_dout;
  logic [7:0] tx_data;
  logic [8:0] mem [2048];
  logic [7:0] got_q [$];
  logic last_q [$];
  int tests = 0, fails = 0;
  int issued, xfers, max_out, stall_bad, lenerr_cnt;
  logic pv;
  logic [8:0] pd;
  logic [5:0] pat = 6'b101001;

  cmd_tx_sequencer #(.MAX_LEN(16)) dut (
    .clk(clk), .reset(reset), .req(req), .ack(ack), .busy(busy),
    .mem_adb(mem_adb), .mem_ceb(mem_ceb), .mem_oce(mem_oce), .mem_dout(mem_dout),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
    .len_err(len_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_ceb) mem_dout <= mem[mem_adb];

  always @(negedge clk) begin
    if (mem_ceb) issued++;
    if (tx_valid && tx_ready) begin
      got_q.push_back(tx_data);
      last_q.push_back(tx_last);
      xfers++;
    end
    if (issued - xfers > max_out) max_out = issued - xfers;
    if (pv && !(tx_valid && {tx_last, tx_data} == pd)) stall_bad++;
    pv = tx_valid && !tx_ready;
    pd = {tx_last, tx_data};
    if (len_err) lenerr_cnt++;
  end

  task automatic check(input string tag, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    got_q.delete();
    last_q.delete();
    issued = 0;
    xfers = 0;
    max_out = 0;
    stall_bad = 0;
    lenerr_cnt = 0;
    pv = 1'b0;
  endtask

  task automatic wait_ack();
    int n = 0;
    while (ack == 2'b00 && n < 100) begin
      tick();
      n++;
    end
    if (ack == 2'b00) check("ack_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin
      tick();
      n++;
    end
    if (busy) check("idle_timeout", 0, 1);
  endtask

  task automatic send0();
    clr();
    req = 2'b01;
    wait_ack();
    req = 2'b00;
    wait_idle();
  endtask

  initial begin
    int n, lasts;
    logic [1:0] order [3];
    logic [10:0] adb1;
    for (int i = 0; i < 2048; i++) mem[i] = 9'h000;
    mem[0] = 9'h055; mem[1] = 9'h0AA; mem[2] = 9'h101;
    mem[1024] = 9'h010; mem[1025] = 9'h011; mem[1026] = 9'h112;
    clr();
    tick();
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_mem", {mem_ceb, mem_adb}, 0);
    check("rst_tx", {tx_valid, tx_last, tx_data, len_err}, 0);
    reset = 1'b0;
    tick();
    // 1: basic packet, latency and gap
    clr();
    req = 2'b01;
    wait_ack();
    req = 2'b00;
    check("t1_ack", ack, 1);
    check("t1_busy", busy, 1);
    check("t1_read0", {mem_ceb, mem_adb}, 'h800);
    tick();
    check("t1_ack_pulse", ack, 0);
    check("t1_early_valid", tx_valid, 0);
    tick(); check("t1_b0", {tx_valid, tx_last, tx_data}, 'h255);
    tick(); check("t1_b1", {tx_valid, tx_last, tx_data}, 'h2AA);
    tick(); check("t1_b2", {tx_valid, tx_last, tx_data}, 'h301);
    n = 0;
    do begin
      tick();
      if (busy) n++;
    end while (busy && n < 100);
    check("t1_gap", n, 12);
    // 2: round robin with both requests held
    reset = 1'b1; tick(); reset = 1'b0; tick();
    clr();
    adb1 = 11'd0;
    req = 2'b11;
    for (int p = 0; p < 3; p++) begin
      wait_ack();
      order[p] = ack;
      if (ack == 2'b10 && mem_ceb) adb1 = mem_adb;
      wait_idle();
    end
    req = 2'b00;
    check("t2_grant0", order[0], 1);
    check("t2_grant1", order[1], 2);
    check("t2_grant2", order[2], 1);
    check("t2_base1", adb1, 1024);
    check("t2_count", got_q.size(), 9);
    if (got_q.size() == 9) check("t2_tmpl1", {got_q[3], got_q[4], got_q[5]}, 'h101112);
    // 3: backpressure on a 6-byte packet
    for (int i = 0; i < 5; i++) mem[i] = 9'(9'h031 + i);
    mem[5] = 9'h136;
    clr();
    req = 2'b01;
    wait_ack();
    req = 2'b00;
    n = 0;
    while (xfers < 6 && n < 100) begin
      tx_ready = pat[n % 6];
      tick();
      n++;
    end
    tx_ready = 1'b1;
    wait_idle();
    check("t3_count", got_q.size(), 6);
    lasts = 0;
    for (int k = 0; k < got_q.size(); k++) begin
      check("t3_byte", got_q[k], 'h31 + k);
      lasts += int'(last_q[k]);
    end
    check("t3_lasts", lasts, 1);
    if (got_q.size() == 6) check("t3_last_pos", last_q[5], 1);
    check("t3_stall_stable", stall_bad, 0);
    check("t3_outstanding_le2", max_out <= 2, 1);
    // 4: unflagged template hits the length guard
    for (int i = 0; i < 32; i++) mem[i] = 9'(9'h040 + i);
    send0();
    check("t4_count", got_q.size(), 16);
    lasts = 0;
    foreach (last_q[k]) lasts += int'(last_q[k]);
    check("t4_lasts", lasts, 1);
    if (got_q.size() == 16) check("t4_final", {last_q[15], got_q[15]}, 'h14F);
    check("t4_len_err", lenerr_cnt, 1);
    mem[0] = 9'h055; mem[1] = 9'h0AA; mem[2] = 9'h101;
    send0();
    check("t4_next_count", got_q.size(), 3);
    if (got_q.size() == 3) check("t4_next_data", {last_q[2], got_q[0], got_q[1], got_q[2]}, 'h155AA01);
    check("t4_next_len_err", lenerr_cnt, 0);
    // 5: single-byte template
    mem[0] = 9'h17E;
    clr();
    req = 2'b01;
    wait_ack();
    req = 2'b00;
    tick(); tick();
    check("t5_byte", {tx_valid, tx_last, tx_data}, 'h37E);
    tick();
    check("t5_after", tx_valid, 0);
    wait_idle();
    check("t5_count", got_q.size(), 1);
    check("t5_reads", issued, 2);
    // 6: reset during the third byte, then replay
    for (int i = 0; i < 5; i++) mem[i] = 9'(9'h061 + i);
    mem[5] = 9'h166;
    clr();
    req = 2'b01;
    wait_ack();
    req = 2'b00;
    n = 0;
    while (!(tx_valid && tx_data == 8'h63) && n < 50) begin
      tick();
      n++;
    end
    check("t6_third", {tx_valid, tx_data}, 'h163);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_tx", {tx_valid, tx_last, tx_data, len_err}, 0);
    check("t6_rst_ctl", {ack, busy, mem_ceb, mem_adb}, 0);
    tick();
    reset = 1'b0;
    tick();
    clr();
    req = 2'b01;
    wait_ack();
    req = 2'b00;
    check("t6_replay_read", {mem_ceb, mem_adb}, 'h800);
    wait_idle();
    check("t6_replay_count", got_q.size(), 6);
    if (got_q.size() == 6) check("t6_replay_data", {last_q[5], got_q[0], got_q[5]}, 'h16166);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
